// File: rtl/tcp_rt_timer.sv
// Per-flow TCP retransmit timer: round-robin scan of armed flows against a free-running
// timestamp, emitting a valid/ready timeout event for each flow that has aged out.
module tcp_rt_timer #(
    parameter int              MAX_FLOW_CNT      = 4,
    parameter int              FLOWID_W          = $clog2(MAX_FLOW_CNT),
    parameter int              TIMESTAMP_W       = 64,
    parameter longint unsigned RT_TIMEOUT_CYCLES = 250000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_timer_val,
    input  logic [FLOWID_W-1:0]    set_timer_flowid,
    input  logic                   set_timer_arm,
    output logic                   set_timer_rdy,
    output logic                   timeout_val,
    output logic [FLOWID_W-1:0]    timeout_flowid,
    input  logic                   timeout_rdy,
    output logic [TIMESTAMP_W-1:0] curr_time
);

    localparam logic [TIMESTAMP_W-1:0] TIMEOUT   = TIMESTAMP_W'(RT_TIMEOUT_CYCLES);
    localparam logic [FLOWID_W-1:0]    LAST_FLOW = FLOWID_W'(MAX_FLOW_CNT - 1);
    localparam logic [0:0]             ST_SCAN   = 1'b0;
    localparam logic [0:0]             ST_EXPIRE = 1'b1;

    logic [TIMESTAMP_W-1:0]  ts_q [MAX_FLOW_CNT];
    logic [MAX_FLOW_CNT-1:0] armed_q;
    logic [TIMESTAMP_W-1:0]  time_q;
    logic [FLOWID_W-1:0]     ptr_q;
    logic [FLOWID_W-1:0]     flowid_q;
    logic [0:0]              state_q;
    logic                    touched_q;
    logic                    rdy_q;

    logic                    set_acc;
    logic                    scan_hit;
    logic                    touch_now;
    logic [FLOWID_W-1:0]     ptr_next;

    // Modular subtraction keeps the age correct across timestamp wrap.
    function automatic logic is_expired(input logic                   armed,
                                        input logic [TIMESTAMP_W-1:0] now,
                                        input logic [TIMESTAMP_W-1:0] stamp);
        logic [TIMESTAMP_W-1:0] elapsed;
        elapsed = now - stamp;
        return armed && (elapsed >= TIMEOUT);
    endfunction

    always_comb begin
        set_acc   = set_timer_val && rdy_q;
        scan_hit  = (state_q == ST_SCAN) && is_expired(armed_q[ptr_q], time_q, ts_q[ptr_q]);
        // A request to the flow being reported hands ownership of its final state to the TX engine.
        touch_now = set_acc &&
                    (set_timer_flowid == ((state_q == ST_SCAN) ? ptr_q : flowid_q));
        ptr_next  = (ptr_q == LAST_FLOW) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_q    <= '0;
            armed_q   <= '0;
            ptr_q     <= '0;
            flowid_q  <= '0;
            state_q   <= ST_SCAN;
            touched_q <= 1'b0;
            rdy_q     <= 1'b0;
            for (int i = 0; i < MAX_FLOW_CNT; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            time_q <= time_q + 1'b1;
            rdy_q  <= 1'b1;

            case (state_q)
                ST_SCAN: begin
                    if (scan_hit) begin
                        flowid_q  <= ptr_q;
                        touched_q <= touch_now;
                        state_q   <= ST_EXPIRE;
                    end else begin
                        ptr_q <= ptr_next;
                    end
                end
                default: begin
                    if (touch_now) begin
                        touched_q <= 1'b1;
                    end
                    if (timeout_rdy) begin
                        if (!touched_q && !touch_now) begin
                            armed_q[flowid_q] <= 1'b0;
                        end
                        touched_q <= 1'b0;
                        ptr_q     <= ptr_next;
                        state_q   <= ST_SCAN;
                    end
                end
            endcase

            if (set_acc) begin
                armed_q[set_timer_flowid] <= set_timer_arm;
                if (set_timer_arm) begin
                    ts_q[set_timer_flowid] <= time_q;
                end
            end
        end
    end

    assign set_timer_rdy  = rdy_q;
    assign timeout_val    = (state_q == ST_EXPIRE);
    assign timeout_flowid = flowid_q;
    assign curr_time      = time_q;

endmodule

// File: tb/tb_tcp_rt_timer.sv
// Directed bench for tcp_rt_timer: a 64-bit-timestamp instance for the main scenarios
// and an 8-bit-timestamp instance for the wrap case.
module tb_tcp_rt_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_timer_val;
    logic [1:0]  set_timer_flowid;
    logic        set_timer_arm;
    logic        set_timer_rdy;
    logic        timeout_val;
    logic [1:0]  timeout_flowid;
    logic        timeout_rdy;
    logic [63:0] curr_time;

    logic        w_rst_n;
    logic        w_set_val;
    logic [1:0]  w_set_flowid;
    logic        w_set_arm;
    logic        w_set_rdy;
    logic        w_val;
    logic [1:0]  w_flowid;
    logic        w_rdy;
    logic [7:0]  w_curr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tcp_rt_timer #(.MAX_FLOW_CNT(4), .TIMESTAMP_W(64), .RT_TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .set_timer_val(set_timer_val), .set_timer_flowid(set_timer_flowid),
        .set_timer_arm(set_timer_arm), .set_timer_rdy(set_timer_rdy),
        .timeout_val(timeout_val), .timeout_flowid(timeout_flowid),
        .timeout_rdy(timeout_rdy), .curr_time(curr_time)
    );

    tcp_rt_timer #(.MAX_FLOW_CNT(4), .TIMESTAMP_W(8), .RT_TIMEOUT_CYCLES(16)) u_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .set_timer_val(w_set_val), .set_timer_flowid(w_set_flowid),
        .set_timer_arm(w_set_arm), .set_timer_rdy(w_set_rdy),
        .timeout_val(w_val), .timeout_flowid(w_flowid),
        .timeout_rdy(w_rdy), .curr_time(w_curr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_timer(input logic [1:0] flow, input logic arm);
        set_timer_val    = 1'b1;
        set_timer_flowid = flow;
        set_timer_arm    = arm;
        tick();
        set_timer_val    = 1'b0;
    endtask

    task automatic wait_val(input int max_cycles, output bit got);
        int i = 0;
        while (!timeout_val && i < max_cycles) begin
            tick();
            i++;
        end
        got = timeout_val;
    endtask

    task automatic count_events(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (timeout_val) cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        timeout_rdy = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (timeout_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b expected 0", timeout_val); end
        n_checks++;
        if (timeout_flowid !== 2'd0) begin n_fail++; $display("FAIL reset_flowid: got %0d expected 0", timeout_flowid); end
        n_checks++;
        if (set_timer_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", set_timer_rdy); end
        n_checks++;
        if (curr_time !== 64'd0) begin n_fail++; $display("FAIL reset_time: got %0d expected 0", curr_time); end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (curr_time !== 64'(k)) begin n_fail++; $display("FAIL count_time: got %0d expected %0d", curr_time, k); end
        end
        n_checks++;
        if (set_timer_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_after_reset: got %b expected 1", set_timer_rdy); end
    endtask

    task automatic test_single_expiry();
        logic [63:0] t;
        bit got;
        int cnt;
        do_reset();
        timeout_rdy = 1'b1;
        t = curr_time;
        set_timer(2'd2, 1'b1);
        wait_val(40, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_event: got no event expected one"); end
        n_checks++;
        if (timeout_flowid !== 2'd2) begin n_fail++; $display("FAIL single_flowid: got %0d expected 2", timeout_flowid); end
        n_checks++;
        if (curr_time < t + 16 || curr_time > t + 21) begin
            n_fail++; $display("FAIL single_time: got %0d expected in [%0d,%0d]", curr_time, t + 16, t + 21);
        end
        count_events(100, cnt);
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL single_no_repeat: got %0d events expected 0", cnt); end
    endtask

    task automatic test_disarm();
        int cnt;
        do_reset();
        timeout_rdy = 1'b1;
        set_timer(2'd1, 1'b1);
        repeat (9) tick();
        set_timer(2'd1, 1'b0);
        count_events(100, cnt);
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL disarm_events: got %0d expected 0", cnt); end
    endtask

    task automatic test_rearm();
        logic [63:0] t;
        bit got;
        do_reset();
        timeout_rdy = 1'b1;
        t = curr_time;
        set_timer(2'd0, 1'b1);
        repeat (9) tick();
        set_timer(2'd0, 1'b1);
        wait_val(40, got);
        n_checks++;
        if (!got || timeout_flowid !== 2'd0) begin
            n_fail++; $display("FAIL rearm_event: got val=%b flow=%0d expected val=1 flow=0", got, timeout_flowid);
        end
        n_checks++;
        if (curr_time < t + 26 || curr_time > t + 31) begin
            n_fail++; $display("FAIL rearm_time: got %0d expected in [%0d,%0d]", curr_time, t + 26, t + 31);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] t;
        bit got;
        bit bad;
        int i;
        int cnt;
        do_reset();
        timeout_rdy = 1'b0;
        while (curr_time[1:0] != 2'd0) tick();
        t = curr_time;
        set_timer(2'd0, 1'b1);
        set_timer(2'd3, 1'b1);
        wait_val(30, got);
        n_checks++;
        if (!got || timeout_flowid !== 2'd0) begin
            n_fail++; $display("FAIL bp_first: got val=%b flow=%0d expected val=1 flow=0", got, timeout_flowid);
        end
        n_checks++;
        if (curr_time > t + 21) begin n_fail++; $display("FAIL bp_detect_time: got %0d expected <= %0d", curr_time, t + 21); end
        bad = 1'b0;
        while (curr_time < t + 60) begin
            if (timeout_val !== 1'b1 || timeout_flowid !== 2'd0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL bp_hold: got unstable event expected flow 0 held"); end
        timeout_rdy = 1'b1;
        tick();
        n_checks++;
        if (timeout_val !== 1'b0) begin n_fail++; $display("FAIL bp_accept_drop: got %b expected 0", timeout_val); end
        i = 0;
        while (!timeout_val && i < 3) begin
            tick();
            i++;
        end
        n_checks++;
        if (timeout_val !== 1'b1 || timeout_flowid !== 2'd3) begin
            n_fail++; $display("FAIL bp_second: got val=%b flow=%0d expected val=1 flow=3", timeout_val, timeout_flowid);
        end
        count_events(50, cnt);
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL bp_no_more: got %0d events expected 0", cnt); end
    endtask

    task automatic test_touch_pending();
        logic [63:0] a;
        bit got;
        do_reset();
        timeout_rdy = 1'b0;
        set_timer(2'd0, 1'b1);
        wait_val(30, got);
        n_checks++;
        if (!got || timeout_flowid !== 2'd0) begin
            n_fail++; $display("FAIL touch_first: got val=%b flow=%0d expected val=1 flow=0", got, timeout_flowid);
        end
        tick();
        tick();
        a = curr_time;
        set_timer(2'd0, 1'b1);
        tick();
        timeout_rdy = 1'b1;
        tick();
        n_checks++;
        if (timeout_val !== 1'b0) begin n_fail++; $display("FAIL touch_accept: got %b expected 0", timeout_val); end
        wait_val(30, got);
        n_checks++;
        if (!got || timeout_flowid !== 2'd0) begin
            n_fail++; $display("FAIL touch_second: got val=%b flow=%0d expected val=1 flow=0", got, timeout_flowid);
        end
        n_checks++;
        if (curr_time < a + 16 || curr_time > a + 21) begin
            n_fail++; $display("FAIL touch_time: got %0d expected in [%0d,%0d]", curr_time, a + 16, a + 21);
        end
    endtask

    task automatic test_reset_mid_expire();
        bit got;
        int cnt;
        do_reset();
        timeout_rdy = 1'b0;
        set_timer(2'd1, 1'b1);
        wait_val(30, got);
        n_checks++;
        if (!got || timeout_flowid !== 2'd1) begin
            n_fail++; $display("FAIL midrst_event: got val=%b flow=%0d expected val=1 flow=1", got, timeout_flowid);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (timeout_val !== 1'b0 || timeout_flowid !== 2'd0) begin
            n_fail++; $display("FAIL midrst_drop: got val=%b flow=%0d expected val=0 flow=0", timeout_val, timeout_flowid);
        end
        rst_n = 1'b1;
        timeout_rdy = 1'b1;
        count_events(40, cnt);
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d events expected 0", cnt); end
    endtask

    task automatic test_wrap();
        int i;
        w_rst_n = 1'b0;
        tick();
        tick();
        w_rst_n = 1'b1;
        w_rdy   = 1'b1;
        i = 0;
        while (w_curr != 8'd250 && i < 300) begin
            tick();
            i++;
        end
        n_checks++;
        if (w_curr !== 8'd250) begin n_fail++; $display("FAIL wrap_reach: got %0d expected 250", w_curr); end
        w_set_val    = 1'b1;
        w_set_flowid = 2'd3;
        w_set_arm    = 1'b1;
        tick();
        w_set_val    = 1'b0;
        i = 0;
        while (!w_val && i < 40) begin
            tick();
            i++;
        end
        n_checks++;
        if (w_val !== 1'b1 || w_flowid !== 2'd3) begin
            n_fail++; $display("FAIL wrap_event: got val=%b flow=%0d expected val=1 flow=3", w_val, w_flowid);
        end
        n_checks++;
        if (w_curr < 8'd10 || w_curr > 8'd15) begin
            n_fail++; $display("FAIL wrap_time: got %0d expected in [10,15]", w_curr);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        set_timer_val    = 1'b0;
        set_timer_flowid = '0;
        set_timer_arm    = 1'b0;
        timeout_rdy      = 1'b1;
        w_rst_n          = 1'b0;
        w_set_val        = 1'b0;
        w_set_flowid     = '0;
        w_set_arm        = 1'b0;
        w_rdy            = 1'b1;

        test_reset();
        test_single_expiry();
        test_disarm();
        test_rearm();
        test_backpressure();
        test_touch_pending();
        test_reset_mid_expire();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
